// File: rtl/pong_game_ctrl.sv
// PONG match sequencer: frame tick, match FSM, scores and serve control.
// Define PONG_AUTO_RESTART_EN to return from GAME_OVER to IDLE after a timeout.
module pong_game_ctrl #(
   parameter int total_col          = 800,
   parameter int total_row          = 525,
   parameter int active_col         = 640,
   parameter int active_row         = 480,
   parameter int score_limit        = 9,
   parameter int serve_delay_frames = 60
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic [9:0] i_X_Cursor,
   input  logic [9:0] i_Y_Cursor,
   input  logic       i_Start,
   input  logic       i_P1_Miss,
   input  logic       i_P2_Miss,
   output logic       o_Frame_Tick,
   output logic       o_Game_Active,
   output logic       o_Ball_Reset,
   output logic       o_Serve_Dir,
   output logic [3:0] o_P1_Score,
   output logic [3:0] o_P2_Score,
   output logic [1:0] o_Winner,
   output logic [2:0] o_State
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] SERVE     = 3'd1;
   localparam logic [2:0] PLAY      = 3'd2;
   localparam logic [2:0] POINT     = 3'd3;
   localparam logic [2:0] GAME_OVER = 3'd4;

   localparam logic [9:0] tick_row   = 10'(active_row);
   localparam logic [9:0] serve_cnt  = 10'(serve_delay_frames);
   localparam logic [9:0] idle_cnt   = 10'(4 * serve_delay_frames);
   localparam logic [3:0] limit      = 4'(score_limit);
   // A frame with no vertical blank can never tick.
   localparam bit         geom_ok    = (active_col < total_col) &&
                                       (active_row < total_row);

   logic       start_d;
   logic       start_evt;
   logic       tick_hit;
   logic [9:0] cnt;
   logic [9:0] cnt_inc;
   logic [2:0] state_n;
   logic [3:0] p1_n;
   logic [3:0] p2_n;
   logic       dir_n;
   logic [1:0] win_n;
   logic [9:0] cnt_n;

   assign start_evt = i_Start & ~start_d;
   assign tick_hit  = geom_ok && (i_X_Cursor == 10'd0) &&
                      (i_Y_Cursor == tick_row);
   assign cnt_inc   = cnt + 10'd1;

   always_comb begin
      state_n = o_State;
      p1_n    = o_P1_Score;
      p2_n    = o_P2_Score;
      dir_n   = o_Serve_Dir;
      win_n   = o_Winner;
      cnt_n   = cnt;
      case (o_State)
         IDLE: begin
            if (start_evt) begin
               state_n = SERVE;
               p1_n    = 4'd0;
               p2_n    = 4'd0;
               dir_n   = 1'b1;
               cnt_n   = 10'd0;
            end
         end
         SERVE: begin
            if (o_Frame_Tick) begin
               if (cnt_inc == serve_cnt) begin
                  state_n = PLAY;
                  cnt_n   = 10'd0;
               end else begin
                  cnt_n   = cnt_inc;
               end
            end
         end
         PLAY: begin
            if (i_P1_Miss && i_P2_Miss) begin
               state_n = SERVE;
               cnt_n   = 10'd0;
            end else if (i_P1_Miss) begin
               p2_n    = o_P2_Score + 4'd1;
               dir_n   = 1'b0;
               state_n = POINT;
            end else if (i_P2_Miss) begin
               p1_n    = o_P1_Score + 4'd1;
               dir_n   = 1'b1;
               state_n = POINT;
            end
         end
         POINT: begin
            cnt_n = 10'd0;
            if (o_P1_Score == limit) begin
               state_n = GAME_OVER;
               win_n   = 2'b01;
            end else if (o_P2_Score == limit) begin
               state_n = GAME_OVER;
               win_n   = 2'b10;
            end else begin
               state_n = SERVE;
            end
         end
         GAME_OVER: begin
            if (start_evt) begin
               state_n = SERVE;
               p1_n    = 4'd0;
               p2_n    = 4'd0;
               win_n   = 2'b00;
               dir_n   = 1'b1;
               cnt_n   = 10'd0;
            end
`ifdef PONG_AUTO_RESTART_EN
            else if (o_Frame_Tick) begin
               if (cnt_inc == idle_cnt) begin
                  state_n = IDLE;
                  p1_n    = 4'd0;
                  p2_n    = 4'd0;
                  win_n   = 2'b00;
                  cnt_n   = 10'd0;
               end else begin
                  cnt_n   = cnt_inc;
               end
            end
`else
            else if (idle_cnt == 10'd0) begin
               cnt_n = 10'd0;
            end
`endif
         end
         default: begin
            state_n = IDLE;
            cnt_n   = 10'd0;
         end
      endcase
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         o_State       <= IDLE;
         o_P1_Score    <= 4'd0;
         o_P2_Score    <= 4'd0;
         o_Winner      <= 2'b00;
         o_Serve_Dir   <= 1'b1;
         o_Frame_Tick  <= 1'b0;
         o_Game_Active <= 1'b0;
         o_Ball_Reset  <= 1'b1;
         cnt           <= 10'd0;
         start_d       <= 1'b0;
      end else begin
         o_State       <= state_n;
         o_P1_Score    <= p1_n;
         o_P2_Score    <= p2_n;
         o_Winner      <= win_n;
         o_Serve_Dir   <= dir_n;
         o_Frame_Tick  <= tick_hit;
         o_Game_Active <= (state_n == PLAY);
         o_Ball_Reset  <= (state_n != PLAY);
         cnt           <= cnt_n;
         start_d       <= i_Start;
      end
   end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomized bench for pong_game_ctrl against a frame/score-level model.
// Build with PONG_AUTO_RESTART_EN to also cover the GAME_OVER timeout.
module tb_pong_game_ctrl;

   localparam int TC = 10;
   localparam int TR = 8;
   localparam int AC = 6;
   localparam int AR = 5;
   localparam int LIM = 3;
   localparam int DLY = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] x = '0;
   logic [9:0] y = '0;
   logic       start = 1'b0;
   logic       p1m = 1'b0;
   logic       p2m = 1'b0;
   logic       tick;
   logic       active;
   logic       ball_rst;
   logic       dir;
   logic [3:0] p1s;
   logic [3:0] p2s;
   logic [1:0] win;
   logic [2:0] st;

   int checks = 0;
   int errors = 0;
   bit run = 0;

   pong_game_ctrl #(
      .total_col(TC), .total_row(TR), .active_col(AC),
      .active_row(AR), .score_limit(LIM), .serve_delay_frames(DLY)
   ) dut (
      .i_Clk(clk), .i_Rst(rst),
      .i_X_Cursor(x), .i_Y_Cursor(y),
      .i_Start(start), .i_P1_Miss(p1m), .i_P2_Miss(p2m),
      .o_Frame_Tick(tick), .o_Game_Active(active),
      .o_Ball_Reset(ball_rst), .o_Serve_Dir(dir),
      .o_P1_Score(p1s), .o_P2_Score(p2s),
      .o_Winner(win), .o_State(st)
   );

   always #5 clk = ~clk;

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Free-running raster cursor
   always @(negedge clk) begin
      if (x == 10'(TC - 1)) begin
         x <= '0;
         y <= (y == 10'(TR - 1)) ? '0 : y + 10'd1;
      end else begin
         x <= x + 10'd1;
      end
   end

   // Behavioural model: match rules applied once per clock
   int  m_state = 0, m_p1 = 0, m_p2 = 0, m_dir = 1, m_win = 0;
   int  m_frames = 0;
   bit  m_tick = 0, m_sd = 0;

   always @(posedge clk or posedge rst) begin
      bit evt;
      if (rst) begin
         m_state = 0; m_p1 = 0; m_p2 = 0; m_dir = 1; m_win = 0;
         m_frames = 0; m_tick = 0; m_sd = 0;
      end else begin
         evt = start && !m_sd;
         case (m_state)
            0: if (evt) begin
                  m_state = 1; m_p1 = 0; m_p2 = 0; m_dir = 1;
                  m_frames = 0;
               end
            1: if (m_tick) begin
                  m_frames++;
                  if (m_frames == DLY) begin
                     m_state = 2; m_frames = 0;
                  end
               end
            2: if (p1m && p2m) begin
                  m_state = 1; m_frames = 0;
               end else if (p1m) begin
                  m_p2++; m_dir = 0; m_state = 3;
               end else if (p2m) begin
                  m_p1++; m_dir = 1; m_state = 3;
               end
            3: begin
                  m_frames = 0;
                  if (m_p1 == LIM) begin m_state = 4; m_win = 1; end
                  else if (m_p2 == LIM) begin m_state = 4; m_win = 2; end
                  else m_state = 1;
               end
            default:
               if (evt) begin
                  m_state = 1; m_p1 = 0; m_p2 = 0; m_win = 0;
                  m_dir = 1; m_frames = 0;
               end
`ifdef PONG_AUTO_RESTART_EN
               else if (m_tick) begin
                  m_frames++;
                  if (m_frames == 4 * DLY) begin
                     m_state = 0; m_p1 = 0; m_p2 = 0; m_win = 0;
                     m_frames = 0;
                  end
               end
`endif
         endcase
         m_tick = (x == 0) && (y == AR);
         m_sd = start;
      end
   end

   logic [9:0] lx, ly;
   always @(posedge clk) begin
      lx <= x;
      ly <= y;
   end

   int cyc = 0;
   int last_tick = -1;
   int serve_entries = 0;
   int prev_st = 0;

   // Single compare process
   always @(negedge clk) begin
      cyc++;
      if (run) begin
         chk("state", st, m_state);
         chk("p1_score", p1s, m_p1);
         chk("p2_score", p2s, m_p2);
         chk("serve_dir", dir, m_dir);
         chk("winner", win, m_win);
         chk("frame_tick", tick, m_tick);
         chk("game_active", active, m_state == 2);
         chk("ball_reset", ball_rst, m_state != 2);
         if (tick && !rst) begin
            chk("tick_cursor_x", lx, 0);
            chk("tick_cursor_y", ly, AR);
            if (last_tick >= 0) chk("tick_period", cyc - last_tick, TC * TR);
            last_tick = cyc;
         end
      end
      if (st == 3'd1 && prev_st != 1) serve_entries++;
      prev_st = st;
   end

   task automatic cycles(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_state(int s, int budget);
      int n = 0;
      while (st != 3'(s) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("wait_state", st, s);
   endtask

   task automatic miss(bit a, bit b);
      p1m = a; p2m = b;
      @(negedge clk);
      p1m = 0; p2m = 0;
   endtask

   initial begin
      cycles(3);
      run = 1;
      chk("rst_state", st, 0);
      chk("rst_ball_reset", ball_rst, 1);
      chk("rst_p1", p1s, 0);
      chk("rst_p2", p2s, 0);
      chk("rst_dir", dir, 1);
      chk("rst_winner", win, 0);
      rst = 0;
      cycles(200);
      chk("idle_hold", st, 0);

      // Held start gives one serve, then PLAY after two ticks
      serve_entries = 0;
      start = 1;
      cycles(200);
      start = 0;
      chk("serve_entries", serve_entries, 1);
      chk("play_after_hold", st, 2);
      chk("active_in_play", active, 1);

      miss(1, 0);
      chk("p1miss_state", st, 3);
      chk("p1miss_p2score", p2s, 1);
      chk("p1miss_dir", dir, 0);
      cycles(1);
      chk("point_to_serve", st, 1);
      wait_state(2, 200);

      miss(1, 1);
      chk("both_state", st, 1);
      chk("both_p1", p1s, 0);
      chk("both_p2", p2s, 1);
      chk("both_dir", dir, 0);

      for (int i = 0; i < 3; i++) begin
         wait_state(2, 300);
         miss(0, 1);
      end
      cycles(1);
      chk("go_state", st, 4);
      chk("go_p1", p1s, 3);
      chk("go_winner", win, 1);
      miss(1, 0);
      miss(0, 1);
      chk("go_ignore_p1", p1s, 3);
      chk("go_ignore_p2", p2s, 1);
`ifdef PONG_AUTO_RESTART_EN
      wait_state(0, 4 * DLY * TC * TR + 100);
      chk("auto_p1", p1s, 0);
      chk("auto_winner", win, 0);
`else
      cycles(4 * DLY * TC * TR + 100);
      chk("go_hold", st, 4);
`endif
      start = 1;
      cycles(1);
      start = 0;
      chk("restart_state", st, 1);
      chk("restart_p1", p1s, 0);
      chk("restart_p2", p2s, 0);

      for (int i = 0; i < 4000; i++) begin
         p1m = ($urandom_range(39) == 0);
         p2m = ($urandom_range(39) == 0);
         if ($urandom_range(199) == 0) begin p1m = 1; p2m = 1; end
         if ($urandom_range(99) == 0) start = ~start;
         @(negedge clk);
      end
      p1m = 0; p2m = 0; start = 0;

      // Reset mid-PLAY at 2:1
      rst = 1;
      cycles(2);
      rst = 0;
      cycles(2);
      start = 1;
      cycles(1);
      start = 0;
      wait_state(2, 300);
      miss(0, 1);
      wait_state(2, 300);
      miss(0, 1);
      wait_state(2, 300);
      miss(1, 0);
      wait_state(2, 300);
      chk("pre_rst_p1", p1s, 2);
      chk("pre_rst_p2", p2s, 1);
      rst = 1;
      #1;
      chk("async_rst_state", st, 0);
      chk("async_rst_p1", p1s, 0);
      chk("async_rst_p2", p2s, 0);
      chk("async_rst_active", active, 0);
      cycles(2);
      rst = 0;
      cycles(20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
